// File: rtl/fcmp_pipe.sv
//==============================================================================
// fcmp_pipe : elastic LAT-stage floating-point compare (FEQ/FLT/FLE).
// Optional NaN handling is enabled by defining FCMP_PIPE_NAN_EN.
// Revision  : 1.0
//==============================================================================
`default_nettype none

module fcmp_pipe #(
   parameter int EW  = 8,
   parameter int MW  = 23,
   parameter int LAT = 2            // legal range 1..4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [EW+MW:0]   x,
   input  logic [EW+MW:0]   y,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             z,
   output logic             nv
);

   localparam int W = 1 + EW + MW;

   localparam logic [1:0] OP_FEQ = 2'b00;
   localparam logic [1:0] OP_FLT = 2'b01;
   localparam logic [1:0] OP_FLE = 2'b10;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
      logic         za;
      logic         zb;
`ifdef FCMP_PIPE_NAN_EN
      logic         na;
      logic         nb;
      logic         sa;
      logic         sb;
`endif
   } stage_t;

   stage_t           cls;
   stage_t           st [LAT];
   stage_t           last;
   logic [LAT-1:0]   vld;
   logic [LAT-1:0]   rdy;

   // Classification ahead of the first stage register.
   always_comb begin
      cls    = '0;
      cls.a  = x;
      cls.b  = y;
      cls.op = op;
      cls.za = (x[W-2:MW] == '0);
      cls.zb = (y[W-2:MW] == '0);
`ifdef FCMP_PIPE_NAN_EN
      cls.na = (&x[W-2:MW]) && (|x[MW-1:0]);
      cls.nb = (&y[W-2:MW]) && (|y[MW-1:0]);
      cls.sa = cls.na && !x[MW-1];
      cls.sb = cls.nb && !y[MW-1];
`endif
   end

   // A stage can take new data when it, or any stage after it, is empty,
   // or when the consumer drains the tail this cycle.
   for (genvar g = 0; g < LAT; g++) begin : g_rdy
      assign rdy[g] = out_ready || !(&vld[LAT-1:g]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld <= '0;
      end else begin
         if (rdy[0])
            vld[0] <= in_valid;
         for (int i = 1; i < LAT; i++)
            if (rdy[i])
               vld[i] <= vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rdy[0] && in_valid)
         st[0] <= cls;
      for (int i = 1; i < LAT; i++)
         if (rdy[i] && vld[i-1])
            st[i] <= st[i-1];
   end

   assign last = st[LAT-1];

   // Ordering and result select on the tail stage; zeros collapse to +0.
   logic          sgn_a;
   logic          sgn_b;
   logic [W-2:0]  mag_a;
   logic [W-2:0]  mag_b;
   logic          eq;
   logic          lt;
   logic          zr;
   logic          nvr;

   always_comb begin
      sgn_a = last.za ? 1'b0 : last.a[W-1];
      sgn_b = last.zb ? 1'b0 : last.b[W-1];
      mag_a = last.za ? '0   : last.a[W-2:0];
      mag_b = last.zb ? '0   : last.b[W-2:0];
      eq    = (sgn_a == sgn_b) && (mag_a == mag_b);
      if (sgn_a != sgn_b)
         lt = sgn_a;
      else if (sgn_a)
         lt = (mag_a > mag_b);
      else
         lt = (mag_a < mag_b);

      zr  = 1'b0;
      nvr = 1'b0;
      case (last.op)
         OP_FEQ:  zr = eq;
         OP_FLT:  zr = lt;
         OP_FLE:  zr = lt || eq;
         default: zr = 1'b0;
      endcase
`ifdef FCMP_PIPE_NAN_EN
      if (last.na || last.nb)
         zr = 1'b0;
      case (last.op)
         OP_FEQ:          nvr = last.sa || last.sb;
         OP_FLT, OP_FLE:  nvr = last.na || last.nb;
         default:         nvr = 1'b0;
      endcase
`endif
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld[LAT-1];
   assign z         = vld[LAT-1] && zr;
   assign nv        = vld[LAT-1] && nvr;

endmodule

`default_nettype wire

// File: tb/tb_fcmp_pipe.sv
//==============================================================================
// tb_fcmp_pipe : randomized and directed checks of fcmp_pipe against a
// value-ordering reference model and an in-order scoreboard.
//==============================================================================
`default_nettype none

module tb_fcmp_pipe;

   localparam int EW  = 8;
   localparam int MW  = 23;
   localparam int LAT = 2;
   localparam int W   = 1 + EW + MW;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  x = '0;
   logic [W-1:0]  y = '0;
   logic [1:0]    op = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          z;
   logic          nv;

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_q [$];
   logic       prev_stall = 1'b0;
   logic       pz, pnv;

   fcmp_pipe #(.EW(EW), .MW(MW), .LAT(LAT)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .nv        (nv)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: map each operand to a signed ordering key (zeros -> 0).
   function automatic logic [1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] o);
      longint ka, kb;
      logic   rz, rnv;
      logic   na, nb, sa, sb;
      ka = (a[W-2:MW] == 0) ? 0 : (a[W-1] ? -longint'(a[W-2:0]) : longint'(a[W-2:0]));
      kb = (b[W-2:MW] == 0) ? 0 : (b[W-1] ? -longint'(b[W-2:0]) : longint'(b[W-2:0]));
      case (o)
         2'd0:    rz = (ka == kb);
         2'd1:    rz = (ka <  kb);
         2'd2:    rz = (ka <= kb);
         default: rz = 1'b0;
      endcase
      rnv = 1'b0;
      na = (a[W-2:MW] == {EW{1'b1}}) && (a[MW-1:0] != 0);
      nb = (b[W-2:MW] == {EW{1'b1}}) && (b[MW-1:0] != 0);
      sa = na && !a[MW-1];
      sb = nb && !b[MW-1];
`ifdef FCMP_PIPE_NAN_EN
      if (na || nb) rz = 1'b0;
      if (o == 2'd1 || o == 2'd2) rnv = na || nb;
      else if (o == 2'd0)         rnv = sa || sb;
`else
      if (na && nb && sa && sb) rnv = 1'b0;
`endif
      return {rz, rnv};
   endfunction

   function automatic logic [W-1:0] rnd_operand();
      logic          s;
      logic [MW-1:0] m;
      s = 1'($urandom_range(0, 1));
      m = MW'($urandom);
      case ($urandom_range(0, 7))
         0:       return {s, {EW{1'b0}}, {MW{1'b0}}};
         1:       return {s, {EW{1'b0}}, m};
         2:       return {s, {EW{1'b1}}, {MW{1'b0}}};
         3:       return {s, {EW{1'b1}}, (m == 0) ? MW'(1) : m};
         default: return {s, EW'($urandom_range(125, 129)), MW'($urandom_range(0, 3)) << (MW-2)};
      endcase
   endfunction

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_z", z, pz);
            check("stall_nv", nv, pnv);
         end
         check("in_ready", in_ready, (exp_q.size() < LAT) || out_ready);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_result", 1, 0);
            end else begin
               logic [1:0] e;
               e = exp_q.pop_front();
               check("res_z", z, e[1]);
               check("res_nv", nv, e[0]);
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(x, y, op));
         prev_stall = out_valid && !out_ready;
         pz  = z;
         pnv = nv;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] o, input logic ez, input logic env);
      int n;
      x = a; y = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_acc"}, in_ready, 1);
      next_cycle();
      in_valid = 1'b0;
      n = 1;
      forever begin
         @(negedge clk);
         if (out_valid || n > 8) break;
         n++;
         next_cycle();
      end
      check({tag, "_lat"}, n, LAT);
      check({tag, "_z"}, z, ez);
      check({tag, "_nv"}, nv, env);
      next_cycle();
   endtask

   initial begin
      logic [W-1:0] sx [8];
      logic [W-1:0] sy [8];
      logic [1:0]   so [8];
      int sent;
      int cyc;

      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_z", z, 0);
      check("rst_nv", nv, 0);
      next_cycle();
      rstn = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      next_cycle();

      directed("feq_pm0", 32'h0000_0000, 32'h8000_0000, 2'b00, 1'b1, 1'b0);
      directed("flt_m1p1", 32'hBF80_0000, 32'h3F80_0000, 2'b01, 1'b1, 1'b0);
      directed("fle_2_1", 32'h4000_0000, 32'h3F80_0000, 2'b10, 1'b0, 1'b0);
      directed("feq_denorm", 32'h0000_0001, 32'h0000_0000, 2'b00, 1'b1, 1'b0);
      directed("flt_pm0", 32'h8000_0000, 32'h0000_0000, 2'b01, 1'b0, 1'b0);
      directed("fle_pm0", 32'h8000_0000, 32'h0000_0000, 2'b10, 1'b1, 1'b0);
      directed("flt_negs", 32'hC000_0000, 32'hBF80_0000, 2'b01, 1'b1, 1'b0);
      directed("op_rsvd", 32'h0000_0000, 32'h0000_0000, 2'b11, 1'b0, 1'b0);
`ifdef FCMP_PIPE_NAN_EN
      directed("fle_qnan", 32'h7FC0_0000, 32'h3F80_0000, 2'b10, 1'b0, 1'b1);
      directed("feq_qnan", 32'h7FC0_0000, 32'h7FC0_0000, 2'b00, 1'b0, 1'b0);
      directed("feq_snan", 32'h7F80_0001, 32'h3F80_0000, 2'b00, 1'b0, 1'b1);
`else
      directed("feq_qnan", 32'h7FC0_0000, 32'h7FC0_0000, 2'b00, 1'b1, 1'b0);
      directed("fle_qnan", 32'h7FC0_0000, 32'h3F80_0000, 2'b10, 1'b0, 1'b0);
`endif

      // Back-to-back stream of 8 with out_ready toggling 1,0,1,0,...
      for (int i = 0; i < 8; i++) begin
         sx[i] = rnd_operand();
         sy[i] = (i % 3 == 0) ? sx[i] : rnd_operand();
         so[i] = 2'($urandom_range(0, 2));
      end
      sent = 0;
      cyc  = 0;
      while ((sent < 8 || exp_q.size() != 0) && cyc < 100) begin
         in_valid  = (sent < 8);
         if (sent < 8) begin
            x = sx[sent]; y = sy[sent]; op = so[sent];
         end
         out_ready = (cyc % 2 == 0);
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         next_cycle();
         cyc++;
      end
      check("stream_done", (sent == 8) && (exp_q.size() == 0), 1);

      // Random traffic with random back-pressure.
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         x  = rnd_operand();
         y  = ($urandom_range(0, 4) == 0) ? x : rnd_operand();
         op = 2'($urandom_range(0, 3));
         next_cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         next_cycle();
      check("drain_empty", exp_q.size(), 0);

      // Reset with results in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x = 32'h3F80_0000; y = 32'h4000_0000; op = 2'b01;
      next_cycle();
      next_cycle();
      in_valid = 1'b0;
      next_cycle();
      check("pre_rst_valid", out_valid, 1);
      #2;
      rstn = 1'b0;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_z", z, 0);
      check("async_nv", nv, 0);
      exp_q.delete();
      next_cycle();
      #2;
      rstn = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_ready", in_ready, 1);
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         @(negedge clk);
         check("post_rst_no_out", out_valid, 0);
      end
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
